// File: rtl/mprj_wb_fifo_pkg.sv
// Shared constants for the Wishbone loopback FIFO: register offsets, bit positions, ID word.
package mprj_wb_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  localparam int unsigned STAT_EMPTY = 16;
  localparam int unsigned STAT_FULL  = 17;
  localparam int unsigned STAT_OVF   = 18;
  localparam int unsigned STAT_UNF   = 19;

  localparam int unsigned CTRL_FLUSH  = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam logic [31:0] FIFO_ID = 32'h4649_464F;

  // Zero the byte lanes whose select bit is low.
  function automatic logic [31:0] mask_lanes(input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? data[8*b +: 8] : 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/mprj_wb_fifo_sync_fifo.sv
// Single-clock FIFO with count, full/empty and flush; push-when-full and pop-when-empty are no-ops.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; valid entries are tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/mprj_wb_fifo.sv
// Wishbone slave exposing a 32-bit loopback FIFO with STATUS/CTRL/ID registers and a level irq.
module mprj_wb_fifo
  import mprj_wb_fifo_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned DEPTH    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        irq_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            hit, rd_hit, wr_hit;
  logic [1:0]      reg_sel;
  logic            push, pop, flush, ctrl_wr;
  logic [31:0]     head, rdata;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic            irq_q, irq_en_q, ovf_q, unf_q;
  logic            unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign hit     = wb_cyc_i & wb_stb_i & (wb_adr_i[31:4] == BASE_ADR[31:4]) & ~ack_q;
  assign rd_hit  = hit & ~wb_we_i;
  assign wr_hit  = hit & wb_we_i;
  assign reg_sel = wb_adr_i[3:2];
  assign push    = wr_hit & (reg_sel == REG_DATA);
  assign pop     = rd_hit & (reg_sel == REG_DATA);
  assign ctrl_wr = wr_hit & (reg_sel == REG_CTRL);
  assign flush   = ctrl_wr & wb_dat_i[CTRL_FLUSH];

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (mask_lanes(wb_dat_i, wb_sel_i)),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_DATA:   rdata = empty ? 32'h0 : head;
      REG_STATUS: begin
        rdata[8:0]        = 9'(count);
        rdata[STAT_EMPTY] = empty;
        rdata[STAT_FULL]  = full;
        rdata[STAT_OVF]   = ovf_q;
        rdata[STAT_UNF]   = unf_q;
      end
      REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
      REG_ID:     rdata = FIFO_ID;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      ack_q <= hit;
      dat_q <= rd_hit ? rdata : 32'h0;
      irq_q <= irq_en_q & ~empty;
      if (ctrl_wr) irq_en_q <= wb_dat_i[CTRL_IRQ_EN];
      // Only one transaction per cycle, so clear and set never collide.
      if (ctrl_wr && wb_dat_i[CTRL_CLR]) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        if (push && full) ovf_q <= 1'b1;
        if (pop && empty) unf_q <= 1'b1;
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_mprj_wb_fifo.sv
// Randomized self-checking bench for mprj_wb_fifo against a queue-based reference model.
module tb_mprj_wb_fifo;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack, irq;
  logic [31:0] rdat;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf = 0, m_unf = 0, m_irq_en = 0;

  always #5 clk = ~clk;

  mprj_wb_fifo #(
    .BASE_ADR (BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_sel_i  (sel),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_ack_o  (ack),
    .wb_dat_o  (rdat),
    .irq_o     (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(q.size());
    if (q.size() == 0)     s = s | 32'h0001_0000;
    if (q.size() == DEPTH) s = s | 32'h0002_0000;
    if (m_ovf)             s = s | 32'h0004_0000;
    if (m_unf)             s = s | 32'h0008_0000;
    return s;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic model_irq();
    return m_irq_en && (q.size() > 0);
  endfunction

  // One bus transaction; called #1 after a rising edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r);
    logic acked = 1'b0;
    logic irq_before;
    irq_before = model_irq();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        break;
      end
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack", {31'h0, acked}, 32'h1);
    check("irq_pre", {31'h0, irq}, {31'h0, irq_before});
  endtask

  // After the model has absorbed a transaction, irq must follow one edge later.
  task automatic settle();
    @(posedge clk); #1;
    check("irq_post", {31'h0, irq}, {31'h0, model_irq()});
    check("ack_drop", {31'h0, ack}, 32'h0);
  endtask

  task automatic do_push(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    xfer(1'b1, BASE + 32'h0, d, s, r);
    if (q.size() == DEPTH) m_ovf = 1;
    else q.push_back(lanes(d, s));
    settle();
  endtask

  task automatic do_pop(output logic [31:0] r);
    logic [31:0] exp;
    xfer(1'b0, BASE + 32'h0, 32'h0, 4'hF, r);
    if (q.size() == 0) begin
      exp = 32'h0;
      m_unf = 1;
    end else begin
      exp = q.pop_front();
    end
    check("pop_data", r, exp);
    settle();
  endtask

  task automatic rd_status(output logic [31:0] r);
    xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, r);
    check("status", r, model_status());
    settle();
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic [31:0] r;
    xfer(1'b1, BASE + 32'h8, v, 4'h0, r);
    if (v[0]) q.delete();
    if (v[1]) begin
      m_ovf = 0;
      m_unf = 0;
    end
    m_irq_en = v[2];
    settle();
  endtask

  task automatic rd_reg(input logic [31:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    xfer(1'b0, BASE + off, 32'h0, 4'hF, r);
    check(tag, r, exp);
    settle();
  endtask

  task automatic wr_ro(input logic [31:0] off);
    logic [31:0] r;
    xfer(1'b1, BASE + off, $urandom, 4'hF, r);
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int unsigned acks;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat", rdat, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd_reg(32'hC, 32'h4649_464F, "id");
    rd_status(r);
    check("status_reset", r, 32'h0001_0000);

    // irq follows non-empty while enabled
    wr_ctrl(32'h4);
    rd_reg(32'h8, 32'h4, "ctrl_rd");
    for (int i = 0; i < 15; i++) do_push(32'h1111_1111 + i, 4'hF);
    for (int i = 0; i < 15; i++) do_pop(r);

    // Full boundary and overflow
    for (int i = 0; i < 17; i++) do_push(32'hA000_0000 + i, 4'hF);
    rd_status(r);
    check("status_full", r, 32'h0006_0010);
    for (int i = 0; i < 16; i++) do_pop(r);
    do_pop(r);
    check("underflow_data", r, 32'h0);
    rd_status(r);
    wr_ctrl(32'h2);
    rd_status(r);
    check("status_cleared", r, 32'h0001_0000);

    do_push(32'hAABB_CCDD, 4'b0101);
    do_pop(r);
    check("sel_mask", r, 32'h00BB_00DD);

    for (int i = 0; i < 3; i++) do_push(32'hC0 + i, 4'hF);
    wr_ctrl(32'h1);
    do_push(32'h5, 4'hF);
    do_pop(r);
    check("after_flush", r, 32'h5);
    rd_status(r);

    // Out-of-window address must never be acked
    acks = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("no_ack_oow", acks, 32'h0);

    // Reset during an acked transaction
    wr_ctrl(32'h4);
    do_push(32'h1234_5678, 4'hF);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h9; sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check("rst_mid_ack", {31'h0, ack}, 32'h0);
    check("rst_mid_irq", {31'h0, irq}, 32'h0);
    q.delete();
    m_ovf = 0; m_unf = 0; m_irq_en = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_status(r);
    check("rst_mid_empty", r, 32'h0001_0000);

    // Random phases alternately biased toward filling and draining
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 80; n++) begin
        int unsigned k = $urandom_range(0, 99);
        int unsigned push_w = (ph % 2 == 0) ? 60 : 20;
        if (k < push_w) do_push($urandom, 4'($urandom_range(0, 15)));
        else if (k < 80) do_pop(r);
        else if (k < 88) rd_status(r);
        else if (k < 93) begin
          logic [31:0] v = 32'h0;
          v[0] = ($urandom_range(0, 7) == 0);
          v[1] = ($urandom_range(0, 3) == 0);
          v[2] = $urandom_range(0, 1);
          wr_ctrl(v);
        end
        else if (k < 96) rd_reg(32'h8, {29'h0, m_irq_en, 2'b00}, "ctrl_rd");
        else if (k < 98) wr_ro(($urandom_range(0, 1) == 0) ? 32'h4 : 32'hC);
        else rd_reg(32'hC, 32'h4649_464F, "id");
      end
    end
    rd_status(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
